// File: rtl/keymgr_kmac_msg_sender_if.sv
// ----------------------------------------------------------------------------
// keymgr_kmac_msg_sender_if
// Purpose : bundles the message-sender <-> KMAC data channel.
//   kmac_data_o : request toward KMAC  {valid, data[63:0], strb[7:0], last}
//   kmac_data_i : response from KMAC   {ready, done, digest_share0[255:0],
//                                        digest_share1[255:0], error}
// Modports:
//   master : the message sender (drives kmac_data_o, observes kmac_data_i)
//   slave  : the KMAC side      (drives kmac_data_i, observes kmac_data_o)
// ----------------------------------------------------------------------------
interface keymgr_kmac_msg_sender_if;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } kmac_data_req_t;

    typedef struct packed {
        logic         ready;
        logic         done;
        logic [255:0] digest_share0;
        logic [255:0] digest_share1;
        logic         error;
    } kmac_data_rsp_t;

    kmac_data_req_t kmac_data_o;
    kmac_data_rsp_t kmac_data_i;

    modport master (output kmac_data_o, input kmac_data_i);
    modport slave  (input kmac_data_o, output kmac_data_i);

endinterface

// File: rtl/keymgr_kmac_msg_sender.sv
// ----------------------------------------------------------------------------
// keymgr_kmac_msg_sender
// Purpose : streams a latched message of up to MsgBytes bytes to KMAC as
//           64-bit beats, then waits for KMAC to finish and captures the two
//           digest shares.
// Parameters:
//   MsgBytes      : maximum message length in bytes (8..256)
//   TimeoutCycles : Wait-state watchdog limit (only with the macro below)
// Optional feature:
//   KEYMGR_KMAC_MSG_TIMEOUT_EN : when defined, a watchdog ends the Wait state
//                                with an error after TimeoutCycles cycles.
// Ports:
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   start_i, msg_i, len_i      : request; sampled only when accepted in Idle
//   kmac                       : data channel to KMAC (master modport)
//   busy_o                     : high in every state except Idle
//   done_o / err_o             : one-cycle completion pulse and its status
//   digest_share0_o/1_o        : captured digest shares
// ----------------------------------------------------------------------------
module keymgr_kmac_msg_sender #(
    parameter int unsigned MsgBytes      = 48,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [MsgBytes*8-1:0]          msg_i,
    input  logic [$clog2(MsgBytes+1)-1:0]  len_i,
    keymgr_kmac_msg_sender_if.master       kmac,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [255:0]                   digest_share0_o,
    output logic [255:0]                   digest_share1_o
);

    localparam int unsigned LenW     = $clog2(MsgBytes + 1);
    localparam int unsigned MaxWords = (MsgBytes + 7) / 8;
    localparam int unsigned MsgW     = MaxWords * 64;
    localparam logic [LenW-1:0] MaxLen = LenW'(MsgBytes);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_WAIT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    state_e           state_r, state_s;
    logic [LenW-1:0]  len_r, len_s;
    logic [LenW-1:0]  cnt_r, cnt_s;
    logic [LenW-1:0]  last_idx_s;
    logic [MsgW-1:0]  msg_r, msg_s;
    logic             capture_s;
    logic             xfer_s;
    logic             err_s;

    logic             valid_r, valid_s;
    logic             last_r, last_s;
    logic [63:0]      data_r, data_s;
    logic [7:0]       strb_r, strb_s;
    logic             busy_r, done_r, err_r;
    logic [255:0]     dig0_r, dig1_r;

    // Copies the message, zeroing every byte at or beyond len so that no
    // stale or undriven bits can ever reach the data bus.
    function automatic logic [MsgW-1:0] mask_msg(input logic [MsgBytes*8-1:0] m,
                                                 input logic [LenW-1:0]       l);
        logic [MsgW-1:0] out_v;
        out_v = {MsgW{1'b0}};
        for (int i = 0; i < int'(MsgBytes); i++) begin
            if (LenW'(i) < l) begin
                out_v[i*8 +: 8] = m[i*8 +: 8];
            end else begin
                out_v[i*8 +: 8] = 8'h00;
            end
        end
        return out_v;
    endfunction

    // Byte enables of the final beat: r = len mod 8 bytes, r = 0 means full.
    function automatic logic [7:0] last_strb(input logic [LenW-1:0] l);
        logic [7:0] s_v;
        if (l[2:0] == 3'd0) begin
            s_v = 8'hFF;
        end else begin
            s_v = (8'h01 << l[2:0]) - 8'h01;
        end
        return s_v;
    endfunction

`ifdef KEYMGR_KMAC_MSG_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
    logic [TimerW-1:0] timer_r;
    logic              timeout_s;

    assign timeout_s = (timer_r == TimerW'(TimeoutCycles - 1));

    // Wait-state watchdog: held at zero outside Wait, so it restarts on entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timer_r <= {TimerW{1'b0}};
        end else if (state_r != ST_WAIT) begin
            timer_r <= {TimerW{1'b0}};
        end else begin
            timer_r <= timer_r + TimerW'(1);
        end
    end
`endif

    assign xfer_s = valid_r && kmac.kmac_data_i.ready;

    // Next-state logic; err_s is only ever set on a transition into Fin so
    // err_o is low whenever done_o is low.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        len_s     = len_r;
        msg_s     = msg_r;
        capture_s = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if ((len_i != LenW'(0)) && (len_i <= MaxLen)) begin
                        msg_s   = mask_msg(msg_i, len_i);
                        len_s   = len_i;
                        cnt_s   = LenW'(0);
                        state_s = ST_TX;
                    end else begin
                        err_s   = 1'b1;
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TX: begin
                // A KMAC completion before our final beat is a protocol fault.
                if (kmac.kmac_data_i.done || kmac.kmac_data_i.error) begin
                    err_s   = 1'b1;
                    state_s = ST_FIN;
                end else if (xfer_s) begin
                    if (cnt_r == last_idx_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        cnt_s = cnt_r + LenW'(1);
                    end
                end else begin
                    state_s = ST_TX;
                end
            end
            ST_WAIT: begin
                if (kmac.kmac_data_i.done) begin
                    capture_s = 1'b1;
                    err_s     = kmac.kmac_data_i.error;
                    state_s   = ST_FIN;
                end else if (kmac.kmac_data_i.error) begin
                    err_s   = 1'b1;
                    state_s = ST_FIN;
                end
`ifdef KEYMGR_KMAC_MSG_TIMEOUT_EN
                else if (timeout_s) begin
                    err_s   = 1'b1;
                    state_s = ST_FIN;
                end
`endif
                else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Index of the final word, derived from the length that will be live
    // next cycle (len >= 1 whenever it is used).
    assign last_idx_s = (len_s - LenW'(1)) >> 3'd3;

    // Next values of the registered KMAC request, computed from the next
    // state so the bus lines up with the state register.
    always_comb begin
        valid_s = (state_s == ST_TX);
        last_s  = 1'b0;
        data_s  = 64'h0;
        strb_s  = 8'h00;
        if (valid_s) begin
            data_s = msg_s[{cnt_s, 6'b000000} +: 64];
            last_s = (cnt_s == last_idx_s);
            if (last_s) begin
                strb_s = last_strb(len_s);
            end else begin
                strb_s = 8'hFF;
            end
        end else begin
            data_s = 64'h0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= LenW'(0);
            len_r   <= LenW'(0);
            msg_r   <= {MsgW{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= 64'h0;
            strb_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            dig0_r  <= 256'h0;
            dig1_r  <= 256'h0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            msg_r   <= msg_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            data_r  <= data_s;
            strb_r  <= strb_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_FIN);
            err_r   <= err_s;
            if (capture_s) begin
                dig0_r <= kmac.kmac_data_i.digest_share0;
                dig1_r <= kmac.kmac_data_i.digest_share1;
            end else begin
                dig0_r <= dig0_r;
                dig1_r <= dig1_r;
            end
        end
    end

    assign kmac.kmac_data_o = '{valid: valid_r, data: data_r, strb: strb_r, last: last_r};
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign err_o           = err_r;
    assign digest_share0_o = dig0_r;
    assign digest_share1_o = dig1_r;

endmodule

// File: tb/tb_keymgr_kmac_msg_sender.sv
// ----------------------------------------------------------------------------
// tb_keymgr_kmac_msg_sender
// Directed and randomized sequences against a byte-level reference model of
// the beat stream (expected data/strb per beat are derived byte by byte from
// the message and its length).
// ----------------------------------------------------------------------------
module tb_keymgr_kmac_msg_sender;

    localparam int MB = 48;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [MB*8-1:0]   msg;
    logic [5:0]        len;
    logic              busy, done, err;
    logic [255:0]      d0, d1;

    keymgr_kmac_msg_sender_if kif();

    keymgr_kmac_msg_sender #(.MsgBytes(MB), .TimeoutCycles(TO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .msg_i           (msg),
        .len_i           (len),
        .kmac            (kif),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .digest_share0_o (d0),
        .digest_share1_o (d1)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [255:0]  exp_d0, exp_d1;
    logic [63:0]   exp_data[$];
    logic [7:0]    exp_strb[$];
    int            sent, vcyc;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic new_msg();
        for (int i = 0; i < MB / 4; i++) msg[i*32 +: 32] = $urandom;
    endtask

    // Reference model: beat k carries bytes 8k..8k+7; bytes past len are 0
    // and their enables are cleared.
    task automatic build_model(input int l);
        int nb;
        logic [63:0] w;
        logic [7:0]  s;
        exp_data.delete();
        exp_strb.delete();
        nb = (l + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            w = 64'h0;
            s = 8'h00;
            for (int b = 0; b < 8; b++) begin
                if (k * 8 + b < l) begin
                    w[b*8 +: 8] = msg[(k*8+b)*8 +: 8];
                    s[b] = 1'b1;
                end
            end
            exp_data.push_back(w);
            exp_strb.push_back(s);
        end
    endtask

    task automatic issue_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = l[5:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Plays the KMAC side of the Tx phase. Returns at the first negedge with
    // valid low. err_beat: beat index at which KMAC raises error.
    task automatic run_tx(input int stall_beat, input int stall_n, input int err_beat,
                          output int n_sent, output int n_valid);
        int  stall_left;
        bit  ended;
        stall_left = stall_n;
        n_sent = 0;
        n_valid = 0;
        ended = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (kif.kmac_data_o.valid !== 1'b1) begin
                ended = 1'b1;
                break;
            end
            n_valid++;
            if (n_sent >= exp_data.size()) begin
                check("tx_extra_beat", n_sent, exp_data.size() - 1);
                ended = 1'b1;
                break;
            end
            check("tx_data", kif.kmac_data_o.data, exp_data[n_sent]);
            check("tx_strb", kif.kmac_data_o.strb, exp_strb[n_sent]);
            check("tx_last", kif.kmac_data_o.last, (n_sent == exp_data.size() - 1));
            if (n_sent == err_beat) begin
                kif.kmac_data_i.ready = 1'b0;
                kif.kmac_data_i.error = 1'b1;
            end else if (n_sent == stall_beat && stall_left > 0) begin
                kif.kmac_data_i.ready = 1'b0;
                stall_left--;
            end else begin
                kif.kmac_data_i.ready = 1'b1;
                n_sent++;
            end
        end
        kif.kmac_data_i.ready = 1'b0;
        check("tx_ended_in_budget", ended, 1);
        check("last_without_valid", kif.kmac_data_o.last, 0);
    endtask

    // Called at the first Wait negedge: idles, then completes with random shares.
    task automatic finish_wait(input int idle_n, input logic kerr);
        logic [255:0] s0, s1;
        for (int i = 0; i < idle_n; i++) begin
            check("wait_no_done", done, 0);
            check("wait_busy", busy, 1);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            s0[i*32 +: 32] = $urandom;
            s1[i*32 +: 32] = $urandom;
        end
        kif.kmac_data_i.done = 1'b1;
        kif.kmac_data_i.error = kerr;
        kif.kmac_data_i.digest_share0 = s0;
        kif.kmac_data_i.digest_share1 = s1;
        exp_d0 = s0;
        exp_d1 = s1;
        @(negedge clk);
        kif.kmac_data_i.done = 1'b0;
        kif.kmac_data_i.error = 1'b0;
        check("fin_done", done, 1);
        check("fin_err", err, kerr);
        check("fin_digest0", d0, exp_d0);
        check("fin_digest1", d1, exp_d1);
        @(negedge clk);
        check("post_done_low", done, 0);
        check("post_idle", busy, 0);
    endtask

    task automatic bad_len(input int l);
        issue_start(l);
        @(negedge clk);
        check("badlen_valid", kif.kmac_data_o.valid, 0);
        check("badlen_done", done, 1);
        check("badlen_err", err, 1);
        @(negedge clk);
        check("badlen_done_once", done, 0);
        check("badlen_idle", busy, 0);
        check("badlen_no_valid", kif.kmac_data_o.valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, kif.kmac_data_o.valid, 0);
        check({tag, "_last"}, kif.kmac_data_o.last, 0);
        check({tag, "_strb"}, kif.kmac_data_o.strb, 0);
        check({tag, "_data"}, kif.kmac_data_o.data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_d0"}, d0, 0);
        check({tag, "_d1"}, d1, 0);
    endtask

    initial begin
        int l, nb;
        rst_n = 1'b0;
        start = 1'b0;
        len   = 6'd0;
        msg   = '0;
        kif.kmac_data_i = '0;
        exp_d0 = 256'h0;
        exp_d1 = 256'h0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Full-length message, ready held high: 6 beats back to back.
        new_msg();
        build_model(48);
        issue_start(48);
        run_tx(-1, 0, -1, sent, vcyc);
        check("len48_beats", sent, 6);
        check("len48_tx_cycles", vcyc, 6);
        check("wait_valid_low", kif.kmac_data_o.valid, 0);
        finish_wait(1, 1'b0);

        // len=13 with a 3-cycle stall on the first beat.
        new_msg();
        build_model(13);
        issue_start(13);
        run_tx(0, 3, -1, sent, vcyc);
        check("len13_beats", sent, 2);
        check("len13_valid_cycles", vcyc, 5);
        finish_wait(0, 1'b0);

        // Illegal lengths.
        bad_len(0);
        bad_len(MB + 1);

        // KMAC error during beat 2 of 6: digests must keep previous values.
        new_msg();
        build_model(48);
        issue_start(48);
        run_tx(-1, 0, 1, sent, vcyc);
        kif.kmac_data_i.error = 1'b0;
        check("txerr_sent", sent, 1);
        check("txerr_done", done, 1);
        check("txerr_err", err, 1);
        check("txerr_dig0", d0, exp_d0);
        check("txerr_dig1", d1, exp_d1);
        @(negedge clk);
        check("txerr_done_once", done, 0);

        // Wait with no KMAC response.
        new_msg();
        l = $urandom_range(1, MB);
        build_model(l);
        issue_start(l);
        run_tx(-1, 0, -1, sent, vcyc);
`ifdef KEYMGR_KMAC_MSG_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            check("timeout_early", done, 0);
            @(negedge clk);
        end
        check("timeout_done", done, 1);
        check("timeout_err", err, 1);
        check("timeout_dig0", d0, exp_d0);
        @(negedge clk);
        check("timeout_done_once", done, 0);
`else
        for (int i = 0; i < 40; i++) begin
            check("nowdog_no_done", done, 0);
            @(negedge clk);
        end
        finish_wait(0, 1'b0);
`endif

        // Reset while waiting, then a late KMAC done must be ignored.
        new_msg();
        build_model(16);
        issue_start(16);
        run_tx(-1, 0, -1, sent, vcyc);
        rst_n = 1'b0;
        @(negedge clk);
        exp_d0 = 256'h0;
        exp_d1 = 256'h0;
        check_all_zero("wait_reset");
        rst_n = 1'b1;
        kif.kmac_data_i.done = 1'b1;
        kif.kmac_data_i.digest_share0 = {8{$urandom}};
        @(negedge clk);
        kif.kmac_data_i.done = 1'b0;
        check_all_zero("late_done");
        new_msg();
        build_model(8);
        issue_start(8);
        run_tx(-1, 0, -1, sent, vcyc);
        check("len8_beats", sent, 1);
        finish_wait(0, 1'b0);

        // Randomized lengths, stalls and completion status.
        for (int it = 0; it < 8; it++) begin
            new_msg();
            l  = $urandom_range(1, MB);
            nb = (l + 7) / 8;
            build_model(l);
            issue_start(l);
            run_tx($urandom_range(0, nb - 1), $urandom_range(0, 3), -1, sent, vcyc);
            check("rand_beats", sent, nb);
            finish_wait($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

endmodule
